instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_pkg.sv | 8 +
 rtl/instr_queue.sv | 86 ++++++++
 tb/tb_instr_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode width constants for the instruction queue and its neighbours.
// Queue depth and almost-full level stay per-instance parameters on the queue itself.
package instr_queue_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 32;

endpackage : instr_queue_pkg

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc} with
// first-word-fall-through head, global stall (rdy_in) and redirect flush.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = INSTR_WIDTH,
    parameter int ADDR_WIDTH  = PC_WIDTH,
    parameter int DEPTH_LOG   = 4,
    parameter int AFULL_LEVEL = (2 ** DEPTH_LOG) - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  push_valid_in,
    input  logic [DATA_WIDTH-1:0] push_instr_in,
    input  logic [ADDR_WIDTH-1:0] push_pc_in,
    output logic                  push_ready_out,
    input  logic                  pop_ready_in,
    output logic                  pop_valid_out,
    output logic [DATA_WIDTH-1:0] pop_instr_out,
    output logic [ADDR_WIDTH-1:0] pop_pc_out,
    output logic [DEPTH_LOG:0]    count_out,
    output logic                  almost_full_out
);

    localparam int                 DEPTH     = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] AFULL_CNT = (DEPTH_LOG + 1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];

    logic [DEPTH_LOG-1:0] head_q;
    logic [DEPTH_LOG-1:0] tail_q;
    logic [DEPTH_LOG:0]   count_q;

    logic push_fire;
    logic pop_fire;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1, rdy_in is 1 and flush_in is 0. push_ready_out/pop_valid_out come
    // from registered count only, so neither depends on the opposite request.
    assign push_ready_out  = (count_q != FULL_CNT);
    assign pop_valid_out   = (count_q != '0);
    assign almost_full_out = (count_q >= AFULL_CNT);
    assign count_out       = count_q;

    assign push_fire = push_valid_in & push_ready_out & rdy_in & ~flush_in;
    assign pop_fire  = pop_valid_out & pop_ready_in & rdy_in & ~flush_in;

    assign pop_instr_out = instr_mem[head_q];
    assign pop_pc_out    = pc_mem[head_q];

    // Storage is deliberately not reset; stale entries are hidden by count.
    always_ff @(posedge clk_in) begin
        if (push_fire) begin
            instr_mem[tail_q] <= push_instr_in;
            pc_mem[tail_q]    <= push_pc_in;
        end
    end

    // Pointers wrap naturally at DEPTH_LOG bits, so entry DEPTH-1 is followed by 0.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_fire) tail_q <= tail_q + 1'b1;
                if (pop_fire)  head_q <= head_q + 1'b1;
                case ({push_fire, pop_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a randomized run,
// all compared against an ordered-list model of the queue contents.
module tb_instr_queue;

    localparam int DEPTH = 16;
    localparam int AFULL = 14;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        push_valid_in;
    logic [31:0] push_instr_in;
    logic [31:0] push_pc_in;
    logic        push_ready_out;
    logic        pop_ready_in;
    logic        pop_valid_out;
    logic [31:0] pop_instr_out;
    logic [31:0] pop_pc_out;
    logic [4:0]  count_out;
    logic        almost_full_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: entries {instr, pc} in arrival order, front is head.
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    instr_queue dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .push_valid_in  (push_valid_in),
        .push_instr_in  (push_instr_in),
        .push_pc_in     (push_pc_in),
        .push_ready_out (push_ready_out),
        .pop_ready_in   (pop_ready_in),
        .pop_valid_out  (pop_valid_out),
        .pop_instr_out  (pop_instr_out),
        .pop_pc_out     (pop_pc_out),
        .count_out      (count_out),
        .almost_full_out(almost_full_out)
    );

    // ---------------- driver ----------------
    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic pv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic pr, input logic fl, input logic rd, input logic rs);
        int n;
        rst_in        = rs;
        rdy_in        = rd;
        flush_in      = fl;
        push_valid_in = pv;
        push_instr_in = ins;
        push_pc_in    = pc;
        pop_ready_in  = pr;
        @(posedge clk_in);
        n = exp_q.size();
        if (!rs) begin
            exp_q.delete();
        end else if (rd) begin
            if (fl) begin
                exp_q.delete();
            end else begin
                if (pr && n > 0) void'(exp_q.pop_front());
                if (pv && n < DEPTH) exp_q.push_back({ins, pc});
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc);
        step(1'b1, $urandom, pc, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Reset must win even with rdy_in low and flush high.
        step(1'b1, 32'h1, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (pop_valid_out !== 1'b0) $display("FAIL reset_pop_valid: got %b expected 0", pop_valid_out);
        else pass_cnt++;
        total_cnt++;
        if (push_ready_out !== 1'b1) $display("FAIL reset_push_ready: got %b expected 1", push_ready_out);
        else pass_cnt++;
        total_cnt++;
        if (count_out !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count_out);
        else pass_cnt++;
        total_cnt++;
        if (almost_full_out !== 1'b0) $display("FAIL reset_afull: got %b expected 0", almost_full_out);
        else pass_cnt++;
    endtask

    task automatic test_fill_three();
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(i * 4));
        total_cnt++;
        if (count_out !== 5'd3) $display("FAIL fill3_count: got %0d expected 3", count_out);
        else pass_cnt++;
        total_cnt++;
        if (pop_pc_out !== 32'h0) $display("FAIL fill3_head_pc: got %h expected 00000000", pop_pc_out);
        else pass_cnt++;
        total_cnt++;
        if (pop_valid_out !== 1'b1) $display("FAIL fill3_pop_valid: got %b expected 1", pop_valid_out);
        else pass_cnt++;
        total_cnt++;
        if (pop_instr_out !== exp_q[0][63:32])
            $display("FAIL fill3_head_instr: got %h expected %h", pop_instr_out, exp_q[0][63:32]);
        else pass_cnt++;
    endtask

    task automatic test_full();
        logic [31:0] refused_pc;
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            push(32'h1000 + 32'(i * 4));
            total_cnt++;
            if (almost_full_out !== (i >= AFULL))
                $display("FAIL full_afull_at_%0d: got %b expected %b", i, almost_full_out, (i >= AFULL));
            else pass_cnt++;
            total_cnt++;
            if (push_ready_out !== (i != DEPTH))
                $display("FAIL full_push_ready_at_%0d: got %b expected %b", i, push_ready_out, (i != DEPTH));
            else pass_cnt++;
        end
        refused_pc = 32'hDEAD_0000;
        step(1'b1, 32'hBAD0_BAD0, refused_pc, 1'b1, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (count_out !== 5'd15) $display("FAIL full_pushpop_count: got %0d expected 15", count_out);
        else pass_cnt++;
        total_cnt++;
        if (pop_pc_out !== 32'h1008) $display("FAIL full_head_advance: got %h expected 00001008", pop_pc_out);
        else pass_cnt++;
        // Drain: refused entry must never show up at the head.
        for (int i = 0; i < 15; i++) begin
            total_cnt++;
            if (pop_pc_out === refused_pc || {pop_instr_out, pop_pc_out} !== exp_q[0])
                $display("FAIL full_drain_%0d: got %h expected %h", i, {pop_instr_out, pop_pc_out}, exp_q[0]);
            else pass_cnt++;
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        total_cnt++;
        if (pop_valid_out !== 1'b0) $display("FAIL full_drained_empty: got %b expected 0", pop_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) push(32'h2000 + 32'(i * 4));
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) push(32'h3000 + 32'(i * 4));
        total_cnt++;
        if (count_out !== 5'd10) $display("FAIL wrap_count: got %0d expected 10", count_out);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (pop_pc_out !== 32'h3000 + 32'(i * 4) || pop_instr_out !== exp_q[0][63:32])
                $display("FAIL wrap_order_%0d: got %h/%h expected %h/%h", i, pop_instr_out, pop_pc_out,
                         exp_q[0][63:32], 32'h3000 + 32'(i * 4));
            else pass_cnt++;
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h4000 + 32'(i * 4));
        step(1'b1, 32'hFFFF_0001, 32'h4F00, 1'b1, 1'b1, 1'b1, 1'b1);
        total_cnt++;
        if (count_out !== 5'd0) $display("FAIL flush_count: got %0d expected 0", count_out);
        else pass_cnt++;
        total_cnt++;
        if (pop_valid_out !== 1'b0) $display("FAIL flush_pop_valid: got %b expected 0", pop_valid_out);
        else pass_cnt++;
        push(32'h5000);
        total_cnt++;
        if (count_out !== 5'd1 || pop_pc_out !== 32'h5000)
            $display("FAIL flush_refill: got %0d/%h expected 1/00005000", count_out, pop_pc_out);
        else pass_cnt++;
    endtask

    task automatic test_rdy_hold();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h6000 + 32'(i * 4));
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 32'h1234_5678, 32'h6F00, 1'b1, 1'b1, 1'b0, 1'b1);
            total_cnt++;
            if (count_out !== 5'd4 || pop_pc_out !== 32'h6000)
                $display("FAIL rdy_hold_%0d: got %0d/%h expected 4/00006000", c, count_out, pop_pc_out);
            else pass_cnt++;
        end
        step(1'b1, 32'h1234_5678, 32'h6010, 1'b1, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (count_out !== 5'd4 || pop_pc_out !== 32'h6004)
            $display("FAIL rdy_resume: got %0d/%h expected 4/00006004", count_out, pop_pc_out);
        else pass_cnt++;
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        push_valid_in = 1'b1;
        push_instr_in = 32'h0000_0013;
        push_pc_in    = 32'h100;
        pop_ready_in  = 1'b1;
        #1;
        total_cnt++;
        if (pop_valid_out !== 1'b0) $display("FAIL empty_same_cycle_valid: got %b expected 0", pop_valid_out);
        else pass_cnt++;
        step(1'b1, 32'h0000_0013, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (pop_valid_out !== 1'b1 || pop_instr_out !== 32'h0000_0013 || pop_pc_out !== 32'h100 ||
            count_out !== 5'd1)
            $display("FAIL empty_push_visible: got %b/%h/%h/%0d expected 1/00000013/00000100/1",
                     pop_valid_out, pop_instr_out, pop_pc_out, count_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic pv, pr, fl, rd, rs;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            if ((i / 150) % 2 == 0) begin
                pv = ($urandom_range(0, 9) < 8);
                pr = ($urandom_range(0, 9) < 3);
            end else begin
                pv = ($urandom_range(0, 9) < 3);
                pr = ($urandom_range(0, 9) < 8);
            end
            fl = ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 199) != 0);
            step(pv, $urandom, $urandom, pr, fl, rd, rs);
            total_cnt++;
            if (count_out !== 5'(exp_q.size()) || pop_valid_out !== (exp_q.size() != 0) ||
                push_ready_out !== (exp_q.size() != DEPTH) || almost_full_out !== (exp_q.size() >= AFULL))
                $display("FAIL rand_status_%0d: got cnt=%0d v=%b r=%b af=%b expected cnt=%0d", i,
                         count_out, pop_valid_out, push_ready_out, almost_full_out, exp_q.size());
            else pass_cnt++;
            if (exp_q.size() != 0) begin
                total_cnt++;
                if ({pop_instr_out, pop_pc_out} !== exp_q[0])
                    $display("FAIL rand_head_%0d: got %h expected %h", i, {pop_instr_out, pop_pc_out}, exp_q[0]);
                else pass_cnt++;
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        push_instr_in = '0;
        push_pc_in    = '0;
        pop_ready_in  = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_fill_three();
        test_full();
        test_wrap();
        test_flush();
        test_rdy_hold();
        test_empty_push_pop();
        test_random();
        idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instr_queue
